// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchroniser plus saturating stability counter that turns a raw,
//   bouncy button level into a clean level and single-cycle press/release pulses.
// Latency: a level change before edge e1, held stable, is reflected after edge e(2^DEBOUNCE_BITS+3).
// Backpressure: none; free-running, every cycle is consumed.
// Ports: Clk (rising edge), Reset (async, active-high), BTN (raw async level),
//   Debounced (filtered level), Press / Release (one-cycle pulses on accepted 0->1 / 1->0).
// Optional feature: define HOLD_REPEAT_EN to re-issue Press every 2^REPEAT_BITS cycles while held.
module button_debounce #(
    parameter int DEBOUNCE_BITS = 20,
    parameter int REPEAT_BITS   = 23
) (
    input  logic Clk,
    input  logic Reset,
    input  logic BTN,
    output logic Debounced,
    output logic Press,
    output logic Release
);

    typedef enum logic [1:0] {
        RELEASED       = 2'd0,
        ARMING_PRESS   = 2'd1,
        PRESSED        = 2'd2,
        ARMING_RELEASE = 2'd3
    } state_t;

    localparam logic [DEBOUNCE_BITS-1:0] CNT_ONE = 1;

    state_t                   state, state_nxt;
    logic                     sync1, sync2;
    logic [DEBOUNCE_BITS-1:0] count, count_nxt;
    logic                     deb_nxt, press_nxt, release_nxt;

`ifdef HOLD_REPEAT_EN
    localparam logic [REPEAT_BITS-1:0] REP_ONE = 1;
    logic [REPEAT_BITS-1:0] rep_cnt, rep_nxt;
`endif

    // Synchroniser and all registered state; the FSM only ever looks at sync2.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            state     <= RELEASED;
            count     <= '0;
            Debounced <= 1'b0;
            Press     <= 1'b0;
            Release   <= 1'b0;
`ifdef HOLD_REPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            sync1     <= BTN;
            sync2     <= sync1;
            state     <= state_nxt;
            count     <= count_nxt;
            Debounced <= deb_nxt;
            Press     <= press_nxt;
            Release   <= release_nxt;
`ifdef HOLD_REPEAT_EN
            rep_cnt   <= rep_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        deb_nxt     = Debounced;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
`ifdef HOLD_REPEAT_EN
        rep_nxt     = rep_cnt;
`endif
        case (state)
            RELEASED: begin
                deb_nxt = 1'b0;
`ifdef HOLD_REPEAT_EN
                rep_nxt = '0;
`endif
                if (sync2) begin
                    state_nxt = ARMING_PRESS;
                    count_nxt = '0;
                end
            end
            ARMING_PRESS: begin
                // The counter saturates into the state change; it never wraps.
                if (!sync2) begin
                    state_nxt = RELEASED;
                end else if (&count) begin
                    state_nxt = PRESSED;
                    deb_nxt   = 1'b1;
                    press_nxt = 1'b1;
`ifdef HOLD_REPEAT_EN
                    rep_nxt   = '0;
`endif
                end else begin
                    count_nxt = count + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!sync2) begin
                    state_nxt = ARMING_RELEASE;
                    count_nxt = '0;
                end
`ifdef HOLD_REPEAT_EN
                else if (&rep_cnt) begin
                    press_nxt = 1'b1;
                    rep_nxt   = '0;
                end else begin
                    rep_nxt = rep_cnt + REP_ONE;
                end
`endif
            end
            ARMING_RELEASE: begin
                // rep_cnt is left alone here so a release glitch keeps the repeat phase.
                if (sync2) begin
                    state_nxt = PRESSED;
                end else if (&count) begin
                    state_nxt   = RELEASED;
                    deb_nxt     = 1'b0;
                    release_nxt = 1'b1;
                end else begin
                    count_nxt = count + CNT_ONE;
                end
            end
            default: state_nxt = RELEASED;
        endcase
    end

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: scenario tasks for the debouncer with DEBOUNCE_BITS=4, REPEAT_BITS=5.
// Expected pulses (kind and absolute edge number) are queued when BTN is driven and
// popped by a negedge monitor whenever Press or Release is seen.
module tb_button_debounce;

    localparam int N   = 4;
    localparam int R   = 5;
    localparam int LAT = (1 << N) + 2;   // edges after e1 until the pulse edge e(2^N+3)

    typedef struct {
        bit is_press;
        int at_edge;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic BTN = 1'b0;
    logic Debounced, Press, Release;

    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    exp_t sb[$];

    button_debounce #(.DEBOUNCE_BITS(N), .REPEAT_BITS(R)) dut (
        .Clk(Clk), .Reset(Reset), .BTN(BTN),
        .Debounced(Debounced), .Press(Press), .Release(Release)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: every observed pulse must match the head of the scoreboard.
    always @(negedge Clk) begin
        if (!Reset && (Press || Release)) begin
            checks++;
            if (Press && Release) begin
                $display("FAIL pulse_exclusive: Press=%b Release=%b at edge %0d, required not both", Press, Release, cyc);
            end else if (sb.size() == 0) begin
                $display("FAIL unexpected_pulse: press=%b at edge %0d, required no pulse", Press, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.is_press !== Press || e.at_edge !== cyc)
                    $display("FAIL pulse: press=%b at edge %0d, required press=%b at edge %0d", Press, cyc, e.is_press, e.at_edge);
                else
                    passes++;
            end
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    task automatic expect_pulse(input bit is_press, input int at_edge);
        exp_t e;
        e.is_press = is_press;
        e.at_edge  = at_edge;
        sb.push_back(e);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb.size() !== 0)
            $display("FAIL %s_drained: %0d pulses outstanding, required 0", name, sb.size());
        else
            passes++;
        sb.delete();
    endtask

    task automatic check_deb(input string name, input logic exp);
        checks++;
        if (Debounced !== exp)
            $display("FAIL %s: Debounced=%b, required %b", name, Debounced, exp);
        else
            passes++;
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if ({Debounced, Press, Release} !== 3'b000)
            $display("FAIL reset_outputs: D/P/R=%b, required 000", {Debounced, Press, Release});
        else
            passes++;
        wait_edges(2);
        Reset = 1'b0;
        wait_edges(3);
        check_deb("reset_release_deb", 1'b0);
    endtask

    task automatic test_press;
        int e1;
        BTN = 1'b1;
        e1 = cyc + 1;
        expect_pulse(1'b1, e1 + LAT);
        wait_edges(LAT);
        check_deb("press_deb_before", 1'b0);
        wait_edges(1);
        check_deb("press_deb_after", 1'b1);
        wait_edges(8);
        check_deb("press_deb_held", 1'b1);
        check_drained("press");
    endtask

    task automatic test_release;
        int e1;
        BTN = 1'b0;
        e1 = cyc + 1;
        expect_pulse(1'b0, e1 + LAT);
        wait_edges(LAT);
        check_deb("release_deb_before", 1'b1);
        wait_edges(1);
        check_deb("release_deb_after", 1'b0);
        wait_edges(8);
        check_drained("release");
    endtask

    task automatic test_bounce;
        int e1;
        for (int i = 0; i < 4; i++) begin
            BTN = (i % 2 == 0);
            wait_edges(3);
        end
        BTN = 1'b1;
        e1 = cyc + 1;
        expect_pulse(1'b1, e1 + LAT);
        wait_edges(LAT + 6);
        check_deb("bounce_deb", 1'b1);
        check_drained("bounce");
        test_release();
    endtask

    task automatic test_short_pulse;
        BTN = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_edges(1);
            check_deb("short_deb_high", 1'b0);
        end
        BTN = 1'b0;
        for (int i = 0; i < 25; i++) begin
            wait_edges(1);
            check_deb("short_deb_low", 1'b0);
        end
        check_drained("short");
    endtask

    task automatic test_reset_mid;
        int e1;
        BTN = 1'b1;
        e1 = cyc + 1;
        expect_pulse(1'b1, e1 + LAT);
        wait_edges(LAT + 4);
        check_drained("mid_prepress");
        Reset = 1'b1;
        #1;
        checks++;
        if ({Debounced, Press, Release} !== 3'b000)
            $display("FAIL reset_mid_async: D/P/R=%b, required 000", {Debounced, Press, Release});
        else
            passes++;
        wait_edges(3);
        Reset = 1'b0;
        e1 = cyc + 1;
        expect_pulse(1'b1, e1 + LAT);
        wait_edges(LAT);
        check_deb("mid_deb_before", 1'b0);
        wait_edges(5);
        check_deb("mid_deb_after", 1'b1);
        check_drained("reset_mid");
        test_release();
    endtask

    task automatic test_hold_repeat;
        int e1;
        BTN = 1'b1;
        e1 = cyc + 1;
        expect_pulse(1'b1, e1 + LAT);
`ifdef HOLD_REPEAT_EN
        for (int k = 1; k <= 3; k++)
            expect_pulse(1'b1, e1 + LAT + k * (1 << R));
`endif
        wait_edges(120);
        BTN = 1'b0;
        e1 = cyc + 1;
        expect_pulse(1'b0, e1 + LAT);
        wait_edges(LAT + 6);
        check_deb("hold_deb_end", 1'b0);
        check_drained("hold_repeat");
    endtask

    initial begin
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_short_pulse();
        test_reset_mid();
        test_hold_repeat();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Front-end conditioner for the push-button inputs (BTNS and siblings) that feeds the board's reset and control logic.
- Synchronises a raw, bouncy, asynchronous button level into the Clk domain and filters it with a saturating stability counter.
- Emits a clean debounced level plus single-cycle press and release pulses.
- Produces the clean button events that the reset-generation logic and user-control FSMs consume.

Parameters:
- DEBOUNCE_BITS, 20, width N of the stability counter; a new level must be stable for 2^N consecutive sampled cycles.
- REPEAT_BITS, 23, width R of the auto-repeat counter; used only when HOLD_REPEAT_EN is defined.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset; clears all state immediately.
- BTN  input  1  raw button level, asynchronous to Clk, may bounce.
- Debounced  output  1  filtered button level, registered.
- Press  output  1  one-Clk-cycle pulse on each accepted 0->1 transition.
- Release  output  1  one-Clk-cycle pulse on each accepted 1->0 transition.

Behaviour:
- Reset (async, active-high):
  - sync1, sync2, count and repeat counter cleared to 0.
  - State forced to RELEASED.
  - Debounced, Press and Release are 0 while Reset is high and on release of Reset.
- Synchroniser: two flops, sync1<=BTN, sync2<=sync1. The FSM sees only sync2.
- Counter: count is N bits, unsigned, never wraps; the only exits are clear-to-0 or a state change.
- Press and Release are registered and default to 0 every cycle unless set below; each is high for exactly one cycle.
- State RELEASED (Debounced=0): if sync2=1 -> ARMING_PRESS, count<=0.
- State ARMING_PRESS (Debounced=0):
  - if sync2=0 -> RELEASED, no pulse;
  - else if count==all-ones -> PRESSED, Debounced<=1, Press<=1;
  - else count<=count+1.
- State PRESSED (Debounced=1): if sync2=0 -> ARMING_RELEASE, count<=0.
- State ARMING_RELEASE (Debounced=1):
  - if sync2=1 -> PRESSED, no pulse;
  - else if count==all-ones -> RELEASED, Debounced<=0, Release<=1;
  - else count<=count+1.
- Latency: with BTN changing before rising edge e1 and held stable, Debounced and the pulse are asserted after rising edge e(2^N+3).
- Glitches: any sync2 reversal during an ARMING state aborts arming with no pulse and no Debounced change.
- Press and Release can never be high in the same cycle.
- Reset mid-operation: outputs drop immediately. If BTN is still held after Reset falls, the press is re-debounced from RELEASED and Press fires again with full latency.
- BTN held constant forever: no further pulses, except auto-repeat when that feature is compiled in.

Optional Feature:
- Macro: HOLD_REPEAT_EN.
- Defined: an R-bit repeat counter.
  - Cleared to 0 on every entry to PRESSED from ARMING_PRESS.
  - Increments each cycle in PRESSED.
  - When it is all-ones in PRESSED, the next edge sets Press<=1 and clears the counter, giving a pulse every 2^R cycles while held.
  - Holds its value in ARMING_RELEASE, so a release glitch does not restart the repeat period.
  - Cleared in RELEASED and by Reset.
- Undefined: no repeat counter is built, REPEAT_BITS is ignored, and Press fires exactly once per accepted press.

Test Plan:
- N=4. Assert Reset mid-sim with BTN=1 -> Debounced, Press and Release go 0 asynchronously before the next edge. After Reset falls, Press pulses once after 19 edges.
- N=4. BTN 0->1 before e1, held -> Press=1 for exactly one cycle after e19; Debounced=1 from e19 on; Release stays 0.
- N=4, pressed state. BTN 1->0, held -> Release=1 for one cycle after e19; Debounced=0 from e19.
- N=4. BTN bounces 1,0,1,0 at 3-cycle intervals, then stays 1 -> no pulse during the bounce; a single Press 19 edges after the final rising transition.
- N=4. BTN high for 10 cycles, then low -> Debounced, Press and Release all stay 0 throughout.
- HOLD_REPEAT_EN, N=4, R=5. Hold BTN high for 120 cycles -> initial Press after e19, then repeat Press pulses every 32 cycles (after e51, e83, e115). Without the macro, only the Press after e19 occurs.
